// File: rtl/btn_pkg.sv
// Shared types and default timing for the button conditioner.
// The optional auto-repeat feature is enabled by defining BTN_REPEAT_EN.
package btn_pkg;

    // Per-channel debounce state.
    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        ARM_HI  = 2'd1,
        IDLE_HI = 2'd2,
        ARM_LO  = 2'd3
    } btn_state_e;

    // Defaults for the 100 MHz board clock.
    localparam int DEF_NUM_BTN       = 2;
    localparam int DEF_DB_CYCLES     = 1_000_000;   // 10 ms
    localparam int DEF_REPEAT_DELAY  = 50_000_000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD = 10_000_000;  // 100 ms

    // Larger of two sizes; used to size the shared repeat counter.
    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM with a saturating
// stability counter, registered level and press/release strobes.
// With BTN_REPEAT_EN defined, a held button also produces auto-repeat presses.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw_i,
    output logic       level_o,
    output logic       press_o,
    output logic       release_o,
    output btn_state_e state_o
);

    localparam int               CNT_W   = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef BTN_REPEAT_EN
    localparam int               RPT_W         = $clog2(max_i(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_M1  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_M1 = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [RPT_W-1:0] RPT_ONE       = RPT_W'(1);

    logic [RPT_W-1:0] rpt_q;        // cycles held since acceptance or last repeat
    logic             rpt_first_q;  // first repeat already emitted
`else
    // Repeat timing is not used in this build; fold it away.
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    logic             s1_q;
    logic             s_q;
    btn_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;

    // Two-stage synchroniser; nothing looks at the raw pad before stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s_q  <= 1'b0;
        end else begin
            s1_q <= btn_raw_i;
            s_q  <= s1_q;
        end
    end

    // Debounce FSM: a change is accepted only after DB_CYCLES+1 consecutive
    // agreeing samples; any opposite sample drops back to the idle state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE_LO;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
`ifdef BTN_REPEAT_EN
            rpt_q       <= '0;
            rpt_first_q <= 1'b0;
`endif
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                IDLE_LO: begin
                    level_q <= 1'b0;
                    if (s_q) begin
                        state_q <= ARM_HI;
                        cnt_q   <= CNT_ONE;
                    end
                end
                ARM_HI: begin
                    if (!s_q) begin
                        state_q <= IDLE_LO;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_MAX) begin
                        state_q <= IDLE_HI;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                IDLE_HI: begin
                    level_q <= 1'b1;
                    if (!s_q) begin
                        state_q <= ARM_LO;
                        cnt_q   <= CNT_ONE;
                    end else begin
`ifdef BTN_REPEAT_EN
                        // First repeat after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
                        if (rpt_first_q ? (rpt_q == RPT_PERIOD_M1) : (rpt_q == RPT_DELAY_M1)) begin
                            press_q     <= 1'b1;
                            rpt_q       <= '0;
                            rpt_first_q <= 1'b1;
                        end else begin
                            rpt_q <= rpt_q + RPT_ONE;
                        end
`endif
                    end
                end
                ARM_LO: begin
                    // Repeat counter is frozen here, not cleared: a bounce back
                    // to IDLE_HI resumes the repeat schedule.
                    if (s_q) begin
                        state_q <= IDLE_HI;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_MAX) begin
                        state_q     <= IDLE_LO;
                        cnt_q       <= '0;
                        level_q     <= 1'b0;
                        release_q   <= 1'b1;
`ifdef BTN_REPEAT_EN
                        rpt_q       <= '0;
                        rpt_first_q <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE_LO;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign state_o   = state_q;

endmodule

// File: rtl/btn_conditioner.sv
// Button conditioner: NUM_BTN independent synchronise/debounce channels
// producing clean levels and one-cycle press/release strobes for the ALU.
// Define BTN_REPEAT_EN to enable auto-repeat presses while a button is held.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN       = DEF_NUM_BTN,
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    // One fully independent channel per button.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_state_e dbg_state_unused;

        btn_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_raw_i(btn_raw[i]),
            .level_o  (btn_level[i]),
            .press_o  (btn_press[i]),
            .release_o(btn_release[i]),
            .state_o  (dbg_state_unused)
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios followed by random button
// activity, all checked cycle by cycle against a run-length reference model.
module tb_btn_conditioner;
    import btn_pkg::*;

    localparam int NUM_BTN = 2;
    localparam int DB      = 4;
    localparam int RDELAY  = 10;
    localparam int RPERIOD = 3;
`ifdef BTN_REPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected {level, press, release} per cycle.
    logic [3*NUM_BTN-1:0] exp_q[$];

    // Reference model state.
    logic [NUM_BTN-1:0] m_s1  = '0;
    logic [NUM_BTN-1:0] m_s2  = '0;
    logic [NUM_BTN-1:0] m_lvl = '0;
    logic [NUM_BTN-1:0] m_press = '0;
    logic [NUM_BTN-1:0] m_rel   = '0;
    int                 m_run  [NUM_BTN];
    int                 m_held [NUM_BTN];

    btn_conditioner #(
        .NUM_BTN      (NUM_BTN),
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (RDELAY),
        .REPEAT_PERIOD(RPERIOD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit repeat_hit(input int held);
        return (held == RDELAY) || ((held > RDELAY) && (((held - RDELAY) % RPERIOD) == 0));
    endfunction

    // Reference model: a channel accepts a new level once the synchronised
    // sample has disagreed with the current level DB+1 times in a row.
    initial begin
        for (int c = 0; c < NUM_BTN; c++) begin
            m_run[c]  = 0;
            m_held[c] = 0;
        end
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
                for (int c = 0; c < NUM_BTN; c++) begin
                    m_run[c]  = 0;
                    m_held[c] = 0;
                end
            end else begin
                for (int c = 0; c < NUM_BTN; c++) begin
                    logic s;
                    s          = m_s2[c];
                    m_s2[c]    = m_s1[c];
                    m_s1[c]    = btn_raw[c];
                    m_press[c] = 1'b0;
                    m_rel[c]   = 1'b0;
                    if (s != m_lvl[c]) begin
                        m_run[c]++;
                        if (m_run[c] == DB + 1) begin
                            m_lvl[c] = s;
                            m_run[c] = 0;
                            if (s) m_press[c] = 1'b1;
                            else begin
                                m_rel[c]  = 1'b1;
                                m_held[c] = 0;
                            end
                        end
                    end else if (m_run[c] != 0) begin
                        m_run[c] = 0;
                    end else if (m_lvl[c] && RPT_ON) begin
                        m_held[c]++;
                        if (repeat_hit(m_held[c])) m_press[c] = 1'b1;
                    end
                end
            end
            exp_q.push_back({m_lvl, m_press, m_rel});
        end
    end

    // Scoreboard: compare every cycle on the falling edge.
    initial begin
        logic [3*NUM_BTN-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("level",   32'(btn_level),   32'(e[3*NUM_BTN-1:2*NUM_BTN]));
                check("press",   32'(btn_press),   32'(e[2*NUM_BTN-1:NUM_BTN]));
                check("release", 32'(btn_release), 32'(e[NUM_BTN-1:0]));
            end
        end
    end

    // Driver tasks
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_raw(input logic [NUM_BTN-1:0] v);
        btn_raw = v;
    endtask

    // Stimulus
    initial begin
        int cnt;
        rst_n   = 1'b0;
        btn_raw = 2'b11;

        // 1. Button held through reset.
        wait_cycles(3);
        check("rst_level",   32'(btn_level),   32'd0);
        check("rst_press",   32'(btn_press),   32'd0);
        check("rst_release", 32'(btn_release), 32'd0);
        check("rst_state",   32'(dut.g_ch[0].u_ch.state_o), 32'(IDLE_LO));
        #2 rst_n = 1'b1;
        wait_cycles(6);
        check("held_lvl_e5", 32'(btn_level), 32'd0);
        wait_cycles(1);
        check("held_lvl_e6", 32'(btn_level), 32'h3);
        check("held_prs_e6", 32'(btn_press), 32'h3);
        wait_cycles(1);
        check("held_prs_e7", 32'(btn_press), 32'd0);
        set_raw(2'b00);
        wait_cycles(12);

        // 2. Clean press and release on channel 0.
        set_raw(2'b01);
        wait_cycles(6);
        check("clean_lvl_e5", 32'(btn_level), 32'd0);
        wait_cycles(1);
        check("clean_prs_e6", 32'(btn_press), 32'h1);
        check("clean_lvl_e6", 32'(btn_level), 32'h1);
        wait_cycles(1);
        check("clean_prs_e7", 32'(btn_press), 32'd0);
        wait_cycles(12);
        set_raw(2'b00);
        wait_cycles(6);
        check("clean_rel_e25", 32'(btn_release), 32'd0);
        wait_cycles(1);
        check("clean_rel_e26", 32'(btn_release), 32'h1);
        check("clean_lvl_e26", 32'(btn_level),   32'd0);
        wait_cycles(12);

        // 3. Bounce: 3 high, 1 low, then held.
        cnt = 0;
        set_raw(2'b01);
        repeat (3) begin wait_cycles(1); if (btn_press[0]) cnt++; end
        set_raw(2'b00);
        wait_cycles(1); if (btn_press[0]) cnt++;
        set_raw(2'b01);
        repeat (6) begin wait_cycles(1); if (btn_press[0]) cnt++; end
        check("bounce_early", 32'(cnt), 32'd0);
        wait_cycles(1);
        check("bounce_prs_e6", 32'(btn_press), 32'h1);
        set_raw(2'b00);
        wait_cycles(12);

        // 4. Simultaneous press, then channel 1 released alone.
        set_raw(2'b11);
        wait_cycles(6);
        check("simul_prs_e5", 32'(btn_press), 32'd0);
        wait_cycles(1);
        check("simul_prs_e6", 32'(btn_press), 32'h3);
        wait_cycles(5);
        set_raw(2'b01);
        wait_cycles(7);
        check("simul_rel1", 32'(btn_release), 32'h2);
        check("simul_lvl1", 32'(btn_level),   32'h1);
        set_raw(2'b00);
        wait_cycles(12);

        // 5. Reset mid-debounce, then reset from a pressed state.
        set_raw(2'b01);
        wait_cycles(3);
        #2 rst_n = 1'b0;
        #1 check("mid_rst_state", 32'(dut.g_ch[0].u_ch.state_o), 32'(IDLE_LO));
        wait_cycles(3);
        #2 rst_n = 1'b1;
        wait_cycles(6);
        check("post_rst_e5", 32'(btn_press), 32'd0);
        wait_cycles(1);
        check("post_rst_e6", 32'(btn_press), 32'h1);
        wait_cycles(3);
        #2 rst_n = 1'b0;
        #1 check("hi_rst_level", 32'(btn_level), 32'd0);
        wait_cycles(2);
        set_raw(2'b00);
        #2 rst_n = 1'b1;
        wait_cycles(12);

        // 6. Long hold: auto-repeat when enabled, single press otherwise.
        cnt = 0;
        set_raw(2'b01);
        repeat (30) begin wait_cycles(1); if (btn_press[0]) cnt++; end
        check("hold_presses", 32'(cnt), RPT_ON ? 32'd6 : 32'd1);
        set_raw(2'b00);
        wait_cycles(20);

        // Random activity with occasional resets.
        for (int seg = 0; seg < 200; seg++) begin
            if ($urandom_range(0, 29) == 0) begin
                #2 rst_n = 1'b0;
                wait_cycles($urandom_range(1, 3));
                #2 rst_n = 1'b1;
            end
            set_raw(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 9) < 7) wait_cycles($urandom_range(1, 6));
            else                          wait_cycles($urandom_range(8, 24));
        end
        set_raw(2'b00);
        wait_cycles(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
